zbreak: RTL and testbench
=========================

Name: zbreak

Overview:
- Z80 breakpoint unit that drives the imm_nmi input of the NMI generator.
- Compares the address of every opcode fetch (M1) against NUM_BP programmable breakpoints. On a hit it raises imm_nmi for the rest of that M1 cycle.
- Sequences through the resulting NMI so the breakpoint cannot retrigger recursively, or on return to the same address.
- Configured and read back through the zports register strobes.

Parameters:
- NUM_BP, 4, number of breakpoint comparators (1..8); index width is 3 bits fixed.
- TMO_W, 8, width of the NMI-acceptance timeout counter, counted in M1 fetches.

Ports:
- rst_n  in  1  asynchronous, active-low reset
- fclk  in  1  system clock
- zpos  in  1  Z80 clock positive-edge strobe (one fclk wide)
- zneg  in  1  Z80 clock negative-edge strobe (one fclk wide)
- m1_n  in  1  Z80 /M1
- mreq_n  in  1  Z80 /MREQ
- rd_n  in  1  Z80 /RD (used only with BRK_WATCH_EN)
- wr_n  in  1  Z80 /WR (used only with BRK_WATCH_EN)
- a  in  16  Z80 address bus
- in_nmi  in  1  NMI-mode flag from the NMI generator
- cfg_wr  in  1  one-fclk write strobe from zports
- cfg_sel  in  3  register select
- cfg_din  in  8  write data
- cfg_dout  out  8  read data for cfg_sel (combinational)
- imm_nmi  out  1  immediate NMI request (level; consumer edge-detects)
- bp_active  out  1  1 when the FSM is not IDLE

Behaviour:
- Fetch detection:
  - m1_n is sampled on zpos; mreq_n is sampled on zneg.
  - fetch = ~(m1_n_s | mreq_n_s).
  - fetch_start = rising edge of fetch, registered on fclk. a is compared in that same fclk.
  - fetch_end = falling edge of fetch.
- Register map (write):
  - 0: IDX[2:0], selects a breakpoint. Values >= NUM_BP: writes to registers 1..3 are ignored.
  - 1: ADDR_LO[idx].
  - 2: ADDR_HI[idx].
  - 3: CTL[idx]: bit0 EN, bit1 ONESHOT (EN clears on hit), bits3:2 TYPE (00 = exec; others reserved unless BRK_WATCH_EN).
  - 4: GCTL: bit0 GEN (global enable), bit1 CLR (self-clearing; zeros HITMASK, HITCNT, LASTIDX).
- Register map (read):
  - 0: IDX.
  - 1/2/3: ADDR_LO/ADDR_HI/CTL of IDX.
  - 4: {6'b0, 0, GEN}.
  - 5: HITMASK (bit n = bp n has hit; sticky; bits >= NUM_BP read 0).
  - 6: HITCNT, 8-bit, saturates at 255.
  - 7: {5'b0, LASTIDX}.
- Reset values: all registers 0, FSM IDLE, imm_nmi=0, bp_active=0.
- Match: exec-type bp n matches when EN[n] and ADDR[n]==a at fetch_start. When several match, the lowest index wins: LASTIDX takes it, and every matching bit is set in HITMASK.
- FSM states:
  - IDLE: GEN=0. No matching. On GEN=1 -> ARMED.
  - ARMED: on fetch_start with a match and in_nmi=0:
    - imm_nmi<=1, HITCNT+1, ONESHOT processing, TMO<=0.
    - -> FIRED.
    - A match while in_nmi=1 is ignored.
  - FIRED: imm_nmi stays 1 until fetch_end, then imm_nmi<=0 -> WAIT_NMI.
  - WAIT_NMI:
    - in_nmi=1 -> IN_NMI.
    - Each fetch_start increments TMO; at all-ones -> ARMED (NMI not accepted).
  - IN_NMI: in_nmi falling -> SKIP.
  - SKIP: the next fetch_start is not compared (RETN target) -> ARMED.
- GEN=0 written in any state -> IDLE with imm_nmi<=0 in the next fclk; writing GEN=0 takes priority over a match in the same cycle.
- A cfg_wr to CTL/ADDR in the same fclk as fetch_start: the comparison uses the old value.
- CLR in the same cycle as a hit: the hit wins, so HITCNT=1 and HITMASK holds only the new bits.
- imm_nmi is low for at least one fclk between requests.
- rst_n asserted mid-FIRED: imm_nmi drops asynchronously.

Optional Feature:
- Macro BRK_WATCH_EN.
- When defined, TYPE selects:
  - 01: memory-read watch, on the registered falling edge of ~(mreq_n|rd_n) with m1_n=1.
  - 10: memory-write watch, on ~(mreq_n|wr_n).
  - 11: either.
- A watch hit follows the same FSM path. fetch_end in FIRED is replaced by the end of the matched access, i.e. mreq_n sampled high on zneg.
- Without the macro: TYPE bits are storable and readable but only 00 can match; rd_n and wr_n are unused.

Test Plan:
- Program bp0=#8000, EN, GEN=1; fetch at #8000 -> imm_nmi high from fetch_start to fetch_end, HITCNT=1, HITMASK=#01, LASTIDX=0.
- Same bp0; in_nmi pulses 1 then 0; next fetch at #8000 -> no imm_nmi (SKIP); the following fetch at #8000 -> imm_nmi again, HITCNT=2.
- bp1 and bp3 both =#1234; fetch #1234 -> LASTIDX=1, HITMASK=#0A.
- bp0 ONESHOT at #0100; fetch twice with an NMI cycle between -> one imm_nmi, CTL[0] reads #02.
- Hit with in_nmi never rising; 255 further fetches -> FSM returns to ARMED, and the next matching fetch fires.
- With BRK_WATCH_EN, bp2 TYPE=10 at #C000; memory write to #C000 -> imm_nmi; memory read of #C000 -> none.

Source files
------------

// File: rtl/zbreak.sv
// ---------------------------------------------------------------------------
// zbreak -- Z80 breakpoint unit feeding the imm_nmi input of the NMI
// generator.
//
// Every opcode fetch (M1) address is compared against NUM_BP programmable
// breakpoints. On a hit imm_nmi is raised until the end of that M1 cycle.
// The FSM then follows the NMI through acceptance, handler execution and
// return. This stops the breakpoint from retriggering inside the handler or
// on the RETN target fetch.
//
// Optional feature macro: BRK_WATCH_EN
//   When defined, CTL.TYPE also selects memory-read / memory-write watch
//   breakpoints. Without it only TYPE=00 (execute) can match, and rd_n/wr_n
//   are unused.
//
// Ports
//   rst_n      async active-low reset
//   fclk       system clock
//   zpos/zneg  one-fclk Z80 clock edge strobes
//   m1_n, mreq_n, rd_n, wr_n, a   Z80 bus
//   in_nmi     NMI-mode flag from the NMI generator
//   cfg_wr/cfg_sel/cfg_din/cfg_dout   zports register access
//   imm_nmi    immediate NMI request (level)
//   bp_active  FSM is not IDLE
//
// Registers (cfg_sel): 0 IDX, 1 ADDR_LO[IDX], 2 ADDR_HI[IDX], 3 CTL[IDX],
//   4 GCTL (bit0 GEN, bit1 CLR self-clearing), 5 HITMASK (ro),
//   6 HITCNT (ro), 7 LASTIDX (ro).
// NUM_BP must be in 1..8.
// ---------------------------------------------------------------------------
module zbreak #(
  parameter int NUM_BP = 4,
  parameter int TMO_W  = 8
) (
  input  logic        rst_n,
  input  logic        fclk,
  input  logic        zpos,
  input  logic        zneg,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] a,
  input  logic        in_nmi,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_sel,
  input  logic [7:0]  cfg_din,
  output logic [7:0]  cfg_dout,
  output logic        imm_nmi,
  output logic        bp_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FIRED,
    S_WAIT_NMI,
    S_IN_NMI,
    S_SKIP
  } state_e;

  state_e             state_q, state_d;
  logic               imm_nmi_q, imm_nmi_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [2:0]         idx_q;
  logic               gen_q;
  logic [15:0]        addr_q [NUM_BP];
  logic [3:0]         ctl_q  [NUM_BP];
  logic [7:0]         hitmask_q, hitmask_d;
  logic [7:0]         hitcnt_q, hitcnt_d;
  logic [2:0]         lastidx_q, lastidx_d;

  logic               m1_n_s_q, mreq_n_s_q, fetch_q;
  logic               fetch, fetch_start, fetch_end;
  logic               access_end;

  logic [7:0]         match;
  logic               any_match;
  logic [2:0]         win_idx;
  logic               hit;

  // -------------------------------------------------------------------------
  // Fetch detection: /M1 is sampled on the Z80 rising edge, /MREQ on the
  // falling edge, so fetch rises half a T-state after /MREQ goes low.
  // Synchronisers idle high so no phantom fetch appears out of reset.
  // -------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m1_n_s_q   <= 1'b1;
      mreq_n_s_q <= 1'b1;
      fetch_q    <= 1'b0;
    end else begin
      if (zpos) m1_n_s_q <= m1_n;
      if (zneg) mreq_n_s_q <= mreq_n;
      fetch_q <= fetch;
    end
  end

  assign fetch       = ~(m1_n_s_q | mreq_n_s_q);
  assign fetch_start = fetch & ~fetch_q;
  assign fetch_end   = ~fetch & fetch_q;

`ifdef BRK_WATCH_EN
  // Data access watch: start is the registered falling edge of the
  // active-low access strobe; end is /MREQ seen high again on zneg.
  logic rd_acc, wr_acc, rd_acc_q, wr_acc_q, mreq_n_s_d1_q;
  logic rd_start, wr_start;
  logic fired_watch_q, fired_watch_d;

  assign rd_acc = ~(mreq_n | rd_n) & m1_n;
  assign wr_acc = ~(mreq_n | wr_n);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_acc_q      <= 1'b0;
      wr_acc_q      <= 1'b0;
      mreq_n_s_d1_q <= 1'b1;
      fired_watch_q <= 1'b0;
    end else begin
      rd_acc_q      <= rd_acc;
      wr_acc_q      <= wr_acc;
      mreq_n_s_d1_q <= mreq_n_s_q;
      fired_watch_q <= fired_watch_d;
    end
  end

  assign rd_start   = rd_acc & ~rd_acc_q;
  assign wr_start   = wr_acc & ~wr_acc_q;
  assign access_end = fired_watch_q ? (mreq_n_s_q & ~mreq_n_s_d1_q) : fetch_end;
`else
  logic unused_watch;
  assign unused_watch = &{1'b0, rd_n, wr_n};
  assign access_end   = fetch_end;
`endif

  // -------------------------------------------------------------------------
  // Comparators. Registered ADDR/CTL are used, so a config write landing in
  // the same fclk as the event is compared against the old value.
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    match   = '0;
    win_idx = '0;
    for (int n = 0; n < NUM_BP; n++) begin
`ifdef BRK_WATCH_EN
      match[n] = ctl_q[n][0] & (addr_q[n] == a) &
                 (((ctl_q[n][3:2] == 2'b00) & fetch_start) |
                  (ctl_q[n][2] & rd_start) | (ctl_q[n][3] & wr_start));
`else
      match[n] = ctl_q[n][0] & (addr_q[n] == a) &
                 (ctl_q[n][3:2] == 2'b00) & fetch_start;
`endif
    end
    // Lowest index wins: scan downward so the last assignment is the lowest.
    for (int n = NUM_BP - 1; n >= 0; n--) begin
      if (match[n]) win_idx = 3'(n);
    end
  end

  assign any_match = |match;

  // -------------------------------------------------------------------------
  // Config write decode
  // -------------------------------------------------------------------------
  logic wr_gctl, gen_off, clr;
  assign wr_gctl = cfg_wr & (cfg_sel == 3'd4);
  assign gen_off = wr_gctl & ~cfg_din[0];
  assign clr     = wr_gctl &  cfg_din[1];

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      imm_nmi_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      imm_nmi_q <= imm_nmi_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    imm_nmi_d = imm_nmi_q;
    tmo_d     = tmo_q;
    hit       = 1'b0;
`ifdef BRK_WATCH_EN
    fired_watch_d = fired_watch_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gen_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        // A hit while already inside an NMI handler is ignored.
        if (any_match && !in_nmi) begin
          hit       = 1'b1;
          imm_nmi_d = 1'b1;
          tmo_d     = '0;
          state_d   = S_FIRED;
`ifdef BRK_WATCH_EN
          fired_watch_d = ~fetch_start;
`endif
        end
      end
      S_FIRED: begin
        if (access_end) begin
          imm_nmi_d = 1'b0;
          state_d   = S_WAIT_NMI;
        end
      end
      S_WAIT_NMI: begin
        if (in_nmi) begin
          state_d = S_IN_NMI;
        end else if (fetch_start) begin
          // Give up once the counter reaches all-ones: NMI was never taken.
          tmo_d = tmo_q + TMO_W'(1);
          if (&tmo_d) state_d = S_ARMED;
        end
      end
      S_IN_NMI: begin
        if (!in_nmi) state_d = S_SKIP;
      end
      S_SKIP: begin
        // The first fetch after the handler is the RETN target; let it pass.
        if (fetch_start) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling wins over anything else, including a hit this cycle.
    if (gen_off || !gen_q) begin
      state_d   = S_IDLE;
      imm_nmi_d = 1'b0;
      hit       = 1'b0;
    end
  end

  assign imm_nmi   = imm_nmi_q;
  assign bp_active = (state_q != S_IDLE);

  // -------------------------------------------------------------------------
  // Hit statistics. A hit coinciding with CLR is applied on top of the
  // cleared values.
  // -------------------------------------------------------------------------
  always_comb begin
    hitmask_d = clr ? 8'h00 : hitmask_q;
    hitcnt_d  = clr ? 8'h00 : hitcnt_q;
    lastidx_d = clr ? 3'd0  : lastidx_q;
    if (hit) begin
      hitmask_d = hitmask_d | match;
      if (hitcnt_d != 8'hFF) hitcnt_d = hitcnt_d + 8'd1;
      lastidx_d = win_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Configuration registers
  // -------------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      gen_q     <= 1'b0;
      hitmask_q <= '0;
      hitcnt_q  <= '0;
      lastidx_q <= '0;
      // NOTE: the breakpoint table is a handful of flops, not a RAM, so it is
      // reset like any other register and never powers up enabled.
      for (int n = 0; n < NUM_BP; n++) begin
        addr_q[n] <= '0;
        ctl_q[n]  <= '0;
      end
    end else begin
      hitmask_q <= hitmask_d;
      hitcnt_q  <= hitcnt_d;
      lastidx_q <= lastidx_d;
      if (cfg_wr && cfg_sel == 3'd0) idx_q <= cfg_din[2:0];
      if (wr_gctl) gen_q <= cfg_din[0];
      for (int n = 0; n < NUM_BP; n++) begin
        // One-shot drops EN on hit; a software CTL write in the same cycle
        // is later in the block and takes precedence.
        if (hit && match[n] && ctl_q[n][1]) ctl_q[n][0] <= 1'b0;
        // IDX values >= NUM_BP match no entry, so those writes are dropped.
        if (cfg_wr && idx_q == 3'(n)) begin
          case (cfg_sel)
            3'd1:    addr_q[n][7:0]  <= cfg_din;
            3'd2:    addr_q[n][15:8] <= cfg_din;
            3'd3:    ctl_q[n]        <= cfg_din[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read-back mux
  // -------------------------------------------------------------------------
  logic [15:0] sel_addr;
  logic [3:0]  sel_ctl;

  always_comb begin
    sel_addr = '0;
    sel_ctl  = '0;
    for (int n = 0; n < NUM_BP; n++) begin
      if (idx_q == 3'(n)) begin
        sel_addr = addr_q[n];
        sel_ctl  = ctl_q[n];
      end
    end
  end

  always_comb begin
    cfg_dout = 8'h00;
    case (cfg_sel)
      3'd0:    cfg_dout = {5'b0, idx_q};
      3'd1:    cfg_dout = sel_addr[7:0];
      3'd2:    cfg_dout = sel_addr[15:8];
      3'd3:    cfg_dout = {4'b0, sel_ctl};
      3'd4:    cfg_dout = {7'b0, gen_q};
      3'd5:    cfg_dout = hitmask_q;
      3'd6:    cfg_dout = hitcnt_q;
      3'd7:    cfg_dout = {5'b0, lastidx_q};
      default: cfg_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_zbreak.sv
// ---------------------------------------------------------------------------
// tb_zbreak -- self-checking bench for zbreak (NUM_BP=4, TMO_W=8).
// Register and fetch vectors are held in a table of records; multi-cycle
// corner cases are hand-written sequences. Expected imm_nmi waveforms for
// each fetch are queued when the fetch is issued and compared when it ends.
// ---------------------------------------------------------------------------
module tb_zbreak;

  logic        rst_n, fclk, zpos, zneg, m1_n, mreq_n, rd_n, wr_n;
  logic [15:0] a;
  logic        in_nmi, cfg_wr;
  logic [2:0]  cfg_sel;
  logic [7:0]  cfg_din, cfg_dout;
  logic        imm_nmi, bp_active;

  zbreak #(.NUM_BP(4), .TMO_W(8)) dut (
    .rst_n     (rst_n),
    .fclk      (fclk),
    .zpos      (zpos),
    .zneg      (zneg),
    .m1_n      (m1_n),
    .mreq_n    (mreq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a         (a),
    .in_nmi    (in_nmi),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_din   (cfg_din),
    .cfg_dout  (cfg_dout),
    .imm_nmi   (imm_nmi),
    .bp_active (bp_active)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  localparam int K_WR = 0;  // register write: sel, data
  localparam int K_RD = 1;  // register read: sel, exp
  localparam int K_FE = 2;  // opcode fetch: data=address, exp=imm_nmi pattern

  // imm_nmi pattern {after compare, mid fetch, before end edge, after end}
  localparam logic [3:0] P_FIRE = 4'b1110;
  localparam logic [3:0] P_NONE = 4'b0000;

  typedef struct {
    int          kind;
    logic [2:0]  sel;
    logic [15:0] data;
    logic [7:0]  exp;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic zp();
    zpos = 1'b1; tick(); zpos = 1'b0;
  endtask

  task automatic zn();
    zneg = 1'b1; tick(); zneg = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [7:0] din);
    cfg_sel = sel; cfg_din = din; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic read_chk(input logic [2:0] sel, input logic [7:0] exp);
    cfg_sel = sel;
    #1;
    check($sformatf("read sel%0d", sel), {8'h00, cfg_dout}, {8'h00, exp});
  endtask

  // Drive an M1 cycle up to the point where the next fclk edge compares.
  task automatic fetch_begin(input logic [15:0] addr);
    a = addr; m1_n = 1'b0; zp();
    mreq_n = 1'b0; zn();
  endtask

  task automatic fetch_finish();
    m1_n = 1'b1; zp();
    mreq_n = 1'b1; zn();
    tick();
  endtask

  task automatic fetch_chk(input logic [15:0] addr, input logic [3:0] exp);
    logic [3:0] seen;
    logic [3:0] want;
    exp_q.push_back(exp);
    fetch_begin(addr);
    tick();        seen[3] = imm_nmi;
    tick();        seen[2] = imm_nmi;
    m1_n = 1'b1; zp();   seen[1] = imm_nmi;
    mreq_n = 1'b1; zn(); seen[0] = imm_nmi;
    tick();
    want = exp_q.pop_front();
    check($sformatf("fetch %h imm_nmi", addr), {12'h000, seen}, {12'h000, want});
  endtask

  task automatic add(input int k, input int sel, input int d, input int e);
    tbl.push_back('{k, 3'(sel), 16'(d), 8'(e)});
  endtask

  task automatic run_vecs();
    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_WR:    cfg_write(tbl[i].sel, tbl[i].data[7:0]);
        K_RD:    read_chk(tbl[i].sel, tbl[i].exp);
        default: fetch_chk(tbl[i].data, tbl[i].exp[3:0]);
      endcase
    end
    tbl.delete();
  endtask

  // NMI accepted, handler runs, RETN: leaves the FSM in SKIP.
  task automatic nmi_cycle();
    in_nmi = 1'b1; tick(); tick();
    in_nmi = 1'b0; tick(); tick();
  endtask

  task automatic rearm();
    cfg_write(3'd4, 8'h00);
    cfg_write(3'd4, 8'h01);
    tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0; zpos = 1'b0; zneg = 1'b0; m1_n = 1'b1; mreq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; a = '0; in_nmi = 1'b0;
    cfg_wr = 1'b0; cfg_sel = '0; cfg_din = '0;
    repeat (3) @(posedge fclk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    check("reset imm_nmi", {15'h0, imm_nmi}, 16'h0);
    check("reset bp_active", {15'h0, bp_active}, 16'h0);
    for (int s = 0; s < 8; s++) read_chk(3'(s), 8'h00);

    // bp0 = #8000 exec, GEN; out-of-range IDX writes dropped; first hit
    add(K_WR, 0, 8'h00, 0); add(K_WR, 1, 8'h00, 0); add(K_WR, 2, 8'h80, 0);
    add(K_WR, 3, 8'h01, 0); add(K_WR, 4, 8'h01, 0);
    add(K_RD, 1, 0, 8'h00); add(K_RD, 2, 0, 8'h80); add(K_RD, 3, 0, 8'h01);
    add(K_RD, 4, 0, 8'h01);
    add(K_WR, 0, 5, 0); add(K_WR, 1, 8'hAA, 0); add(K_RD, 0, 0, 8'h05);
    add(K_RD, 1, 0, 8'h00);
    add(K_WR, 0, 1, 0); add(K_RD, 1, 0, 8'h00); add(K_WR, 0, 0, 0);
    add(K_RD, 1, 0, 8'h00);
    add(K_FE, 0, 16'h8000, P_FIRE);
    add(K_RD, 6, 0, 8'h01); add(K_RD, 5, 0, 8'h01); add(K_RD, 7, 0, 8'h00);
    run_vecs();
    check("bp_active after hit", {15'h0, bp_active}, 16'h1);

    // NMI round trip: RETN target fetch skipped, next fetch fires again
    nmi_cycle();
    add(K_FE, 0, 16'h8000, P_NONE);
    add(K_FE, 0, 16'h8000, P_FIRE);
    add(K_RD, 6, 0, 8'h02);
    add(K_WR, 4, 8'h03, 0);                       // CLR, GEN kept
    add(K_RD, 5, 0, 8'h00); add(K_RD, 6, 0, 8'h00); add(K_RD, 4, 0, 8'h01);
    run_vecs();
    cfg_write(3'd4, 8'h00);
    tick();
    check("GEN=0 -> idle", {14'h0, bp_active, imm_nmi}, 16'h0);
    rearm();

    // bp1 and bp3 share #1234: lowest index wins, both recorded
    add(K_WR, 0, 1, 0); add(K_WR, 1, 8'h34, 0); add(K_WR, 2, 8'h12, 0); add(K_WR, 3, 8'h01, 0);
    add(K_WR, 0, 3, 0); add(K_WR, 1, 8'h34, 0); add(K_WR, 2, 8'h12, 0); add(K_WR, 3, 8'h01, 0);
    add(K_FE, 0, 16'h1234, P_FIRE);
    add(K_RD, 7, 0, 8'h01); add(K_RD, 5, 0, 8'h0A); add(K_RD, 6, 0, 8'h01);
    run_vecs();
    rearm();

    // Match while in_nmi=1 is ignored
    in_nmi = 1'b1;
    fetch_chk(16'h8000, P_NONE);
    in_nmi = 1'b0;
    tick();
    read_chk(3'd6, 8'h01);

    // One-shot bp0 at #0100
    add(K_WR, 0, 0, 0); add(K_WR, 1, 8'h00, 0); add(K_WR, 2, 8'h01, 0); add(K_WR, 3, 8'h03, 0);
    add(K_FE, 0, 16'h0100, P_FIRE);
    run_vecs();
    nmi_cycle();
    add(K_FE, 0, 16'h0000, P_NONE);               // RETN target
    add(K_FE, 0, 16'h0100, P_NONE);
    add(K_RD, 3, 0, 8'h02); add(K_RD, 5, 0, 8'h0B); add(K_RD, 6, 0, 8'h02);
    add(K_RD, 7, 0, 8'h00);
    run_vecs();

    // NMI never accepted: 255 fetches time out, the next one fires
    fetch_chk(16'h1234, P_FIRE);
    for (int i = 0; i < 255; i++) fetch_chk(16'h1234, P_NONE);
    check("bp_active during timeout", {15'h0, bp_active}, 16'h1);
    fetch_chk(16'h1234, P_FIRE);
    read_chk(3'd6, 8'h04);
    read_chk(3'd7, 8'h01);

    // CLR in the same fclk as a hit: hit applied after clear
    rearm();
    fetch_begin(16'h1234);
    cfg_sel = 3'd4; cfg_din = 8'h03; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("hit with CLR imm_nmi", {15'h0, imm_nmi}, 16'h1);
    fetch_finish();
    read_chk(3'd6, 8'h01);
    read_chk(3'd5, 8'h0A);

    // GEN=0 written in the compare cycle beats the match
    rearm();
    fetch_begin(16'h1234);
    cfg_sel = 3'd4; cfg_din = 8'h00; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("GEN=0 vs match", {14'h0, bp_active, imm_nmi}, 16'h0);
    fetch_finish();
    read_chk(3'd6, 8'h01);

    // CTL write in the compare cycle: old value used
    rearm();
    cfg_write(3'd0, 8'h01);
    fetch_begin(16'h1234);
    cfg_sel = 3'd3; cfg_din = 8'h00; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("CTL write vs compare", {15'h0, imm_nmi}, 16'h1);
    fetch_finish();
    read_chk(3'd3, 8'h00);
    read_chk(3'd6, 8'h02);

    // Async reset while FIRED (bp3 still armed at #1234)
    rearm();
    fetch_begin(16'h1234);
    tick();
    check("fired before reset", {15'h0, imm_nmi}, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset imm_nmi", {14'h0, bp_active, imm_nmi}, 16'h0);
    m1_n = 1'b1; mreq_n = 1'b1;
    rst_n = 1'b1;
    tick();
    read_chk(3'd5, 8'h00);
    read_chk(3'd6, 8'h00);

    // TYPE=10 bp never matches an opcode fetch; TYPE bits read back
    add(K_WR, 0, 2, 0); add(K_WR, 1, 8'h00, 0); add(K_WR, 2, 8'hC0, 0);
    add(K_WR, 3, 8'h09, 0); add(K_WR, 4, 8'h01, 0);
    add(K_FE, 0, 16'hC000, P_NONE);
    add(K_RD, 3, 0, 8'h09);
    run_vecs();

`ifdef BRK_WATCH_EN
    // Memory write to #C000 hits the write watch; a read does not
    begin
      logic [3:0] seen;
      a = 16'hC000; m1_n = 1'b1; mreq_n = 1'b0; wr_n = 1'b0;
      tick();        seen[3] = imm_nmi;
      zn();          seen[2] = imm_nmi;
      mreq_n = 1'b1; wr_n = 1'b1;
      zn();          seen[1] = imm_nmi;
      tick();        seen[0] = imm_nmi;
      check("watch write imm_nmi", {12'h0, seen}, {12'h0, P_FIRE});
      rearm();
      mreq_n = 1'b0; rd_n = 1'b0;
      tick();        seen[3] = imm_nmi;
      zn();          seen[2] = imm_nmi;
      mreq_n = 1'b1; rd_n = 1'b1;
      zn();          seen[1] = imm_nmi;
      tick();        seen[0] = imm_nmi;
      check("watch read imm_nmi", {12'h0, seen}, {12'h0, P_NONE});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
